// File: rtl/sar_pkg.sv
// Shared types and default constants for the SAR conversion sequencer.
package sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_CONV   = 2'd2
  } sar_state_e;

  localparam int SAR_NBITS      = 10;
  localparam int SAR_SAMPLE_CYC = 4;
  localparam int SAR_CMP_CYC    = 2;

endpackage

// File: rtl/sar_phase_cnt.sv
// Loadable down-counter with a terminal-count flag. It stops at zero
// instead of wrapping, so tc stays high until the next load.
module sar_phase_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         tc
);

  // Load takes priority; otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/sar_conv_seq.sv
// SAR conversion sequencer: sample phase, then one comparator-clock burst
// per bit (MSB first), capturing decisions into the trial DAC code.
//
// Handshake: start is a request sampled only while IDLE (no ready is
// returned; a start seen while busy is dropped). valid is a one-cycle
// strobe qualifying result; there is no back-pressure on the output.
// All outputs come straight from flops.
module sar_conv_seq
  import sar_pkg::*;
#(
  parameter int NBITS      = SAR_NBITS,
  parameter int SAMPLE_CYC = SAR_SAMPLE_CYC,
  parameter int CMP_CYC    = SAR_CMP_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_out,
  output logic             sample_en,
  output logic             cmp_clk_en,
  output logic [NBITS-1:0] dac_code,
  output logic [NBITS-1:0] result,
  output logic             valid,
  output logic             busy
);

  localparam int BW = $clog2(NBITS);
  localparam int PW = $clog2(CMP_CYC) + 1;
  localparam int SW = $clog2(SAMPLE_CYC) + 1;
  // One counter times both phases, so size it for the longer load value.
  localparam int CW = (SW > PW) ? SW : PW;

  sar_state_e       state, state_nxt;
  logic [BW-1:0]    bit_idx, bit_nxt, bit_dn;
  logic [NBITS-1:0] dac_nxt, dac_dec, result_nxt;
  logic             valid_nxt, busy_nxt, sample_nxt, cmp_nxt;
  logic             cnt_load;
  logic [CW-1:0]    cnt_load_val, cnt_val;
  logic             cnt_tc;

  sar_phase_cnt #(.W(CW)) u_phase_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .count    (cnt_val),
    .tc       (cnt_tc)
  );

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      dac_code   <= '0;
      result     <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      sample_en  <= 1'b0;
      cmp_clk_en <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_idx    <= bit_nxt;
      dac_code   <= dac_nxt;
      result     <= result_nxt;
      valid      <= valid_nxt;
      busy       <= busy_nxt;
      sample_en  <= sample_nxt;
      cmp_clk_en <= cmp_nxt;
    end
  end

  // Next-state and next-output logic; abort overrides everything outside IDLE.
  always_comb begin
    state_nxt    = state;
    bit_nxt      = bit_idx;
    dac_nxt      = dac_code;
    result_nxt   = result;
    valid_nxt    = 1'b0;
    busy_nxt     = busy;
    sample_nxt   = sample_en;
    cmp_nxt      = cmp_clk_en;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    bit_dn       = bit_idx - 1'b1;
    // Current code with this bit's comparator decision applied.
    dac_dec      = dac_code;
    if (cmp_out) dac_dec[bit_idx] = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt    = ST_SAMPLE;
          busy_nxt     = 1'b1;
          sample_nxt   = 1'b1;
          dac_nxt      = '0;
          cnt_load     = 1'b1;
          cnt_load_val = CW'(SAMPLE_CYC - 1);
        end
      end
      ST_SAMPLE: begin
        if (cnt_tc) begin
          state_nxt          = ST_CONV;
          sample_nxt         = 1'b0;
          cmp_nxt            = 1'b1;
          bit_nxt            = BW'(NBITS - 1);
          dac_nxt            = '0;
          dac_nxt[NBITS-1]   = 1'b1;
          cnt_load           = 1'b1;
          cnt_load_val       = CW'(CMP_CYC - 1);
        end
      end
      ST_CONV: begin
        if (cnt_tc) begin
          if (bit_idx == '0) begin
            state_nxt  = ST_IDLE;
            result_nxt = dac_dec;
            valid_nxt  = 1'b1;
            busy_nxt   = 1'b0;
            cmp_nxt    = 1'b0;
            dac_nxt    = dac_dec;
          end else begin
            // Next bit starts at phase 0 with no gap in the burst.
            bit_nxt         = bit_dn;
            dac_nxt         = dac_dec;
            dac_nxt[bit_dn] = 1'b1;
            cnt_load        = 1'b1;
            cnt_load_val    = CW'(CMP_CYC - 1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (abort && (state != ST_IDLE)) begin
      state_nxt  = ST_IDLE;
      busy_nxt   = 1'b0;
      sample_nxt = 1'b0;
      cmp_nxt    = 1'b0;
      dac_nxt    = '0;
      valid_nxt  = 1'b0;
      result_nxt = result;
      cnt_load   = 1'b0;
    end
  end

endmodule

// File: tb/tb_sar_conv_seq.sv
// Bench for sar_conv_seq: directed conversions against a comparator model
// cmp_out = (dac_code > vin), with a result scoreboard and a per-cycle
// phase tracker.
module tb_sar_conv_seq;
  import sar_pkg::*;

  localparam int NB  = SAR_NBITS;
  localparam int SC  = SAR_SAMPLE_CYC;
  localparam int CC  = SAR_CMP_CYC;
  localparam int LAT = 25;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          cmp_out;
  logic          sample_en;
  logic          cmp_clk_en;
  logic [NB-1:0] dac_code;
  logic [NB-1:0] result;
  logic          valid;
  logic          busy;
  logic [NB-1:0] vin;

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;

  logic [NB-1:0] exp_q[$];
  int            cyc_q[$];

  logic          trk_active = 1'b0;
  int            trk_k = 0;
  logic [NB-1:0] trk_vin = '0;
  logic          prev_valid = 1'b0;

  int mon_c, mon_o, mon_b, mon_m;
  int k;

  sar_conv_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cmp_out    (cmp_out),
    .sample_en  (sample_en),
    .cmp_clk_en (cmp_clk_en),
    .dac_code   (dac_code),
    .result     (result),
    .valid      (valid),
    .busy       (busy)
  );

  assign cmp_out = (dac_code > vin);

  // Clock and edge counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, edge_cnt + 1);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Advance until the current cycle index reaches c.
  task automatic wait_until(input int c);
    while (edge_cnt + 1 < c) step();
  endtask

  // Pulse start for one cycle and push the expected result.
  task automatic launch(input logic [NB-1:0] v);
    vin        = v;
    start      = 1'b1;
    trk_k      = edge_cnt + 1;
    trk_vin    = v;
    trk_active = 1'b1;
    exp_q.push_back(v);
    cyc_q.push_back(trk_k + LAT);
    step();
    start = 1'b0;
  endtask

  // Monitor: invariants, scoreboard pop on valid, per-cycle phase checks.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_c = edge_cnt + 1;
      chk("sample_cmp_excl", 32'(sample_en & cmp_clk_en), 32'd0);
      chk("valid_twice", 32'(valid & prev_valid), 32'd0);
      chk("busy_in_valid", 32'(busy & valid), 32'd0);
      prev_valid = valid;
      if (valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 32'd1, 32'd0);
        end else begin
          chk("result", 32'(result), 32'(exp_q.pop_front()));
          chk("valid_cycle", 32'(mon_c), 32'(cyc_q.pop_front()));
        end
      end else if (cyc_q.size() > 0 && cyc_q[0] <= mon_c) begin
        chk("missing_valid", 32'd0, 32'd1);
        void'(exp_q.pop_front());
        void'(cyc_q.pop_front());
      end
      if (trk_active) begin
        mon_o = mon_c - trk_k;
        if (mon_o >= 1 && mon_o <= SC) begin
          chk("sample_phase", 32'({sample_en, cmp_clk_en, busy, dac_code}),
              32'({3'b101, {NB{1'b0}}}));
        end else if (mon_o > SC && mon_o <= SC + NB * CC) begin
          // Bits above the trial bit already equal vin's bits.
          mon_b = NB - 1 - (mon_o - SC - 1) / CC;
          mon_m = ((int'(trk_vin) >> (mon_b + 1)) << (mon_b + 1)) | (1 << mon_b);
          chk("conv_phase", 32'({sample_en, cmp_clk_en, busy, dac_code}),
              32'({3'b011, NB'(mon_m)}));
        end else if (mon_o == LAT) begin
          chk("done_phase", 32'({sample_en, cmp_clk_en, busy, dac_code}),
              32'({3'b000, trk_vin}));
          trk_active = 1'b0;
        end
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Directed stimulus.
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    vin   = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", 32'({sample_en, cmp_clk_en, busy, valid, dac_code, result}), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic conversions, including both extremes.
    launch(10'h2A5);
    wait_until(trk_k + LAT + 2);
    launch(10'h000);
    wait_until(trk_k + LAT + 2);
    launch(10'h3FF);
    wait_until(trk_k + LAT + 2);

    // start while busy is dropped; start in the valid cycle is taken.
    launch(10'h0F0);
    k = trk_k;
    wait_until(k + 10);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_until(k + LAT);
    chk("valid_cycle_start", 32'(valid), 32'd1);
    launch(10'h30F);
    wait_until(trk_k + LAT + 2);

    // Abort mid-conversion after a prior result of 0x155.
    launch(10'h155);
    wait_until(trk_k + LAT + 2);
    launch(10'h3F0);
    k = trk_k;
    wait_until(k + 12);
    abort = 1'b1;
    step();
    abort = 1'b0;
    trk_active = 1'b0;
    void'(exp_q.pop_back());
    void'(cyc_q.pop_back());
    chk("abort_outputs", 32'({sample_en, cmp_clk_en, busy, valid, dac_code}), 32'd0);
    chk("abort_result", 32'(result), 32'h155);
    wait_until(k + LAT + 3);
    chk("abort_result_kept", 32'(result), 32'h155);
    // abort while IDLE does nothing.
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort", 32'({busy, result}), 32'h155);
    launch(10'h0AA);
    wait_until(trk_k + LAT + 2);

    // Asynchronous reset mid-conversion.
    launch(10'h3C3);
    wait_until(trk_k + 8);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({sample_en, cmp_clk_en, busy, valid, dac_code, result}), 32'd0);
    trk_active = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    step();
    rst_n = 1'b1;
    step();
    launch(10'h001);
    wait_until(trk_k + LAT + 3);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
